// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and FSM state encoding for the register-file access controller.
package regfile_ctrl_pkg;

  localparam int RF_ADDR_W = 3;
  localparam int RF_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_CAPTURE,
    RD_HOLD
  } state_e;

endpackage

// File: rtl/regfile_access_ctrl_arb.sv
// rr_arbiter2: two-requester round-robin arbiter (write vs read).
// The priority flop only toggles when both requesters collide.
module rr_arbiter2 #(
  parameter bit WR_FIRST_RESET = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en_i,
  input  logic wr_req_i,
  input  logic rd_req_i,
  output logic wr_gnt_o,
  output logic rd_gnt_o
);

  logic wr_prio_q;
  logic wr_prio_d;

  always_comb begin
    wr_gnt_o  = en_i && wr_req_i && (!rd_req_i || wr_prio_q);
    rd_gnt_o  = en_i && rd_req_i && (!wr_req_i || !wr_prio_q);
    wr_prio_d = wr_prio_q;
    if (en_i && wr_req_i && rd_req_i) begin
      wr_prio_d = !wr_prio_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_prio_q <= WR_FIRST_RESET;
    end else begin
      wr_prio_q <= wr_prio_d;
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequences writeback and operand reads onto an 8x16 register file.
// Optional REGFILE_ACCESS_ZERO_R0_EN hardwires register 0 to zero.
module regfile_access_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDR_W         = RF_ADDR_W,
  parameter int DATA_W         = RF_DATA_W,
  parameter int WR_FIRST_RESET = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_rs,
  input  logic [ADDR_W-1:0] rd_req_rt,
  output logic              rd_rsp_valid,
  input  logic              rd_rsp_ready,
  output logic [DATA_W-1:0] rd_rsp_rs_data,
  output logic [DATA_W-1:0] rd_rsp_rt_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_rs_addr,
  output logic [ADDR_W-1:0] rf_rt_addr,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] rf_rs_data,
  input  logic [DATA_W-1:0] rf_rt_data
);

  state_e            state_q;
  logic              active_q;
  logic              rf_write_q;
  logic [ADDR_W-1:0] rf_rs_addr_q;
  logic [ADDR_W-1:0] rf_rt_addr_q;
  logic [ADDR_W-1:0] rf_rd_addr_q;
  logic [DATA_W-1:0] rf_data_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rs_q;
  logic [DATA_W-1:0] rsp_rt_q;

  logic              arb_en;
  logic              wr_gnt;
  logic              rd_gnt;
  logic              wr_en;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  // Hold off grants for the first cycle out of reset so readies start low.
  assign arb_en = active_q && (state_q == IDLE);

  rr_arbiter2 #(
    .WR_FIRST_RESET (WR_FIRST_RESET != 0)
  ) u_arb (
    .clock    (clock),
    .reset_n  (reset_n),
    .en_i     (arb_en),
    .wr_req_i (wr_req_valid),
    .rd_req_i (rd_req_valid),
    .wr_gnt_o (wr_gnt),
    .rd_gnt_o (rd_gnt)
  );

`ifdef REGFILE_ACCESS_ZERO_R0_EN
  assign wr_en  = (wr_req_addr != '0);
  assign rs_val = (rf_rs_addr_q == '0) ? '0 : rf_rs_data;
  assign rt_val = (rf_rt_addr_q == '0) ? '0 : rf_rt_data;
`else
  assign wr_en  = 1'b1;
  assign rs_val = rf_rs_data;
  assign rt_val = rf_rt_data;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      active_q     <= 1'b0;
      rf_write_q   <= 1'b0;
      rf_rs_addr_q <= '0;
      rf_rt_addr_q <= '0;
      rf_rd_addr_q <= '0;
      rf_data_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rs_q     <= '0;
      rsp_rt_q     <= '0;
    end else begin
      active_q <= 1'b1;
      case (state_q)
        IDLE: begin
          unique case (1'b1)
            wr_gnt: begin
              rf_rd_addr_q <= wr_req_addr;
              rf_data_q    <= wr_req_data;
              rf_write_q   <= wr_en;
              state_q      <= WR_ISSUE;
            end
            rd_gnt: begin
              rf_rs_addr_q <= rd_req_rs;
              rf_rt_addr_q <= rd_req_rt;
              state_q      <= RD_ISSUE;
            end
            default: ;
          endcase
        end
        WR_ISSUE: begin
          rf_write_q <= 1'b0;
          state_q    <= IDLE;
        end
        RD_ISSUE: begin
          state_q <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          rsp_rs_q <= rs_val;
          rsp_rt_q <= rt_val;
          state_q  <= RD_HOLD;
        end
        RD_HOLD: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rd_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_req_ready   = wr_gnt;
  assign rd_req_ready   = rd_gnt;
  assign rf_write       = rf_write_q;
  assign rf_rs_addr     = rf_rs_addr_q;
  assign rf_rt_addr     = rf_rt_addr_q;
  assign rf_rd_addr     = rf_rd_addr_q;
  assign rf_data        = rf_data_q;
  assign rd_rsp_valid   = rsp_valid_q;
  assign rd_rsp_rs_data = rsp_rs_q;
  assign rd_rsp_rt_data = rsp_rt_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl with a behavioural register file.
module tb_regfile_access_ctrl;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          rd_req_valid = 1'b0;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_rs = '0;
  logic [AW-1:0] rd_req_rt = '0;
  logic          rd_rsp_valid;
  logic          rd_rsp_ready = 1'b0;
  logic [DW-1:0] rd_rsp_rs_data;
  logic [DW-1:0] rd_rsp_rt_data;
  logic          wr_req_valid = 1'b0;
  logic          wr_req_ready;
  logic [AW-1:0] wr_req_addr = '0;
  logic [DW-1:0] wr_req_data = '0;
  logic          rf_write;
  logic [AW-1:0] rf_rs_addr;
  logic [AW-1:0] rf_rt_addr;
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_data;
  logic [DW-1:0] rf_rs_data;
  logic [DW-1:0] rf_rt_data;

  always #5 clock = ~clock;

  regfile_access_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rd_req_valid   (rd_req_valid),
    .rd_req_ready   (rd_req_ready),
    .rd_req_rs      (rd_req_rs),
    .rd_req_rt      (rd_req_rt),
    .rd_rsp_valid   (rd_rsp_valid),
    .rd_rsp_ready   (rd_rsp_ready),
    .rd_rsp_rs_data (rd_rsp_rs_data),
    .rd_rsp_rt_data (rd_rsp_rt_data),
    .wr_req_valid   (wr_req_valid),
    .wr_req_ready   (wr_req_ready),
    .wr_req_addr    (wr_req_addr),
    .wr_req_data    (wr_req_data),
    .rf_write       (rf_write),
    .rf_rs_addr     (rf_rs_addr),
    .rf_rt_addr     (rf_rt_addr),
    .rf_rd_addr     (rf_rd_addr),
    .rf_data        (rf_data),
    .rf_rs_data     (rf_rs_data),
    .rf_rt_data     (rf_rt_data)
  );

  // Register file with registered dual read, preloaded from init_val.
  logic [DW-1:0] rf_mem   [8];
  logic [DW-1:0] init_val [8];
  logic [DW-1:0] ref_mem  [8];
  logic          rf_load = 1'b1;

  always @(posedge clock) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= init_val[i];
    end else if (rf_write) begin
      rf_mem[rf_rd_addr] <= rf_data;
    end
    rf_rs_data <= rf_mem[rf_rs_addr];
    rf_rt_data <= rf_mem[rf_rt_addr];
  end

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
`ifdef REGFILE_ACCESS_ZERO_R0_EN
    if (a == 0) return '0;
`endif
    return ref_mem[a];
  endfunction

  function automatic logic exp_we(input logic [AW-1:0] a);
`ifdef REGFILE_ACCESS_ZERO_R0_EN
    return a != 0;
`else
    return a == a;
`endif
  endfunction

  always @(negedge clock) begin
    if (reset_n) check("ready_excl", {31'b0, rd_req_ready && wr_req_ready}, 0);
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    wr_req_addr  = a;
    wr_req_data  = d;
    wr_req_valid = 1'b1;
    #1;
    n = 0;
    while (!wr_req_ready && n < 20) begin
      step();
      n++;
    end
    check("wr_ready", {31'b0, wr_req_ready}, 1);
    step();
    wr_req_valid = 1'b0;
    check("wr_rf_write", {31'b0, rf_write}, {31'b0, exp_we(a)});
    check("wr_rf_rd_addr", {29'b0, rf_rd_addr}, {29'b0, a});
    check("wr_rf_data", {16'b0, rf_data}, {16'b0, d});
    step();
    check("wr_rf_write_drop", {31'b0, rf_write}, 0);
    if (exp_we(a)) ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input int hold);
    int n;
    logic [DW-1:0] ers;
    logic [DW-1:0] ert;
    rd_req_rs    = rs;
    rd_req_rt    = rt;
    rd_req_valid = 1'b1;
    #1;
    n = 0;
    while (!rd_req_ready && n < 20) begin
      step();
      n++;
    end
    check("rd_ready", {31'b0, rd_req_ready}, 1);
    ers = exp_rd(rs);
    ert = exp_rd(rt);
    step();
    rd_req_valid = 1'b0;
    check("rd_rs_addr", {29'b0, rf_rs_addr}, {29'b0, rs});
    check("rd_rt_addr", {29'b0, rf_rt_addr}, {29'b0, rt});
    step();
    check("rsp_early1", {31'b0, rd_rsp_valid}, 0);
    step();
    check("rsp_early2", {31'b0, rd_rsp_valid}, 0);
    step();
    check("rsp_valid", {31'b0, rd_rsp_valid}, 1);
    check("rsp_rs", {16'b0, rd_rsp_rs_data}, {16'b0, ers});
    check("rsp_rt", {16'b0, rd_rsp_rt_data}, {16'b0, ert});
    if (hold > 0) begin
      wr_req_addr  = 3'd1;
      wr_req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        #1;
        check("bp_valid", {31'b0, rd_rsp_valid}, 1);
        check("bp_rs", {16'b0, rd_rsp_rs_data}, {16'b0, ers});
        check("bp_rt", {16'b0, rd_rsp_rt_data}, {16'b0, ert});
        check("bp_wr_ready", {31'b0, wr_req_ready}, 0);
        step();
      end
      wr_req_valid = 1'b0;
    end
    rd_rsp_ready = 1'b1;
    step();
    rd_rsp_ready = 1'b0;
    check("rsp_drop", {31'b0, rd_rsp_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      init_val[i] = 16'($urandom_range(1, 16'hFFFF));
      ref_mem[i]  = init_val[i];
    end
    repeat (3) step();
    check("rst_rf_write", {31'b0, rf_write}, 0);
    check("rst_rsp_valid", {31'b0, rd_rsp_valid}, 0);
    check("rst_wr_ready", {31'b0, wr_req_ready}, 0);
    check("rst_rd_ready", {31'b0, rd_req_ready}, 0);
    check("rst_rf_rs_addr", {29'b0, rf_rs_addr}, 0);
    check("rst_rf_data", {16'b0, rf_data}, 0);
    check("rst_rsp_rs", {16'b0, rd_rsp_rs_data}, 0);
    rf_load = 1'b0;
    reset_n = 1'b1;
    step();

    // Both channels held valid: write, read, write.
    wr_req_addr  = 3'd5;
    wr_req_data  = 16'h5A5A;
    rd_req_rs    = 3'd5;
    rd_req_rt    = 3'd2;
    rd_rsp_ready = 1'b1;
    wr_req_valid = 1'b1;
    rd_req_valid = 1'b1;
    #1;
    check("arb1_wr", {31'b0, wr_req_ready}, 1);
    check("arb1_rd", {31'b0, rd_req_ready}, 0);
    step();
    check("arb_rf_write", {31'b0, rf_write}, {31'b0, exp_we(3'd5)});
    check("arb_wi_rd", {31'b0, rd_req_ready}, 0);
    if (exp_we(3'd5)) ref_mem[5] = 16'h5A5A;
    step();
    check("arb2_rd", {31'b0, rd_req_ready}, 1);
    check("arb2_wr", {31'b0, wr_req_ready}, 0);
    step();
    check("arb_ri_wr", {31'b0, wr_req_ready}, 0);
    step();
    step();
    check("arb_rsp_early", {31'b0, rd_rsp_valid}, 0);
    step();
    check("arb_rsp_valid", {31'b0, rd_rsp_valid}, 1);
    check("arb_rsp_rs", {16'b0, rd_rsp_rs_data}, {16'b0, exp_rd(3'd5)});
    check("arb_rsp_rt", {16'b0, rd_rsp_rt_data}, {16'b0, exp_rd(3'd2)});
    step();
    check("arb_rsp_drop", {31'b0, rd_rsp_valid}, 0);
    check("arb3_wr", {31'b0, wr_req_ready}, 1);
    check("arb3_rd", {31'b0, rd_req_ready}, 0);
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;
    rd_rsp_ready = 1'b0;
    step();

    do_write(3'd3, 16'hBEEF);
    do_read(3'd3, 3'd0, 0);
    check("beef_direct", {16'b0, rd_rsp_rs_data}, {16'b0, 16'hBEEF});
    do_write(3'd7, 16'h1234);
    do_read(3'd7, 3'd7, 0);
    check("rs_eq_rt", {16'b0, rd_rsp_rt_data}, {16'b0, 16'h1234});
    do_read(3'd3, 3'd5, 10);
    do_write(3'd0, 16'hFFFF);
    do_read(3'd0, 3'd0, 0);

    // Reset during RD_CAPTURE abandons the read.
    rd_req_rs    = 3'd3;
    rd_req_rt    = 3'd7;
    rd_req_valid = 1'b1;
    #1;
    check("mid_rd_ready", {31'b0, rd_req_ready}, 1);
    step();
    rd_req_valid = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    check("mid_rf_write", {31'b0, rf_write}, 0);
    check("mid_rs_addr", {29'b0, rf_rs_addr}, 0);
    check("mid_rt_addr", {29'b0, rf_rt_addr}, 0);
    check("mid_rd_addr", {29'b0, rf_rd_addr}, 0);
    check("mid_rf_data", {16'b0, rf_data}, 0);
    check("mid_rsp_rs", {16'b0, rd_rsp_rs_data}, 0);
    check("mid_rsp_rt", {16'b0, rd_rsp_rt_data}, 0);
    check("mid_rsp_valid", {31'b0, rd_rsp_valid}, 0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("no_stray_rsp", {31'b0, rd_rsp_valid}, 0);
    end

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(3'($urandom_range(0, 7)), 16'($urandom));
      else
        do_read(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
